keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad on the board's input header and reports debounced key presses to downstream logic. It is the input-side counterpart to the LED/switch output logic: it drives column lines, reads row lines, and filters bounce. It produces one key code plus a single-cycle valid pulse per physical press. It runs from the 24 MHz HSOSC-derived clock.

## Interface
Parameters:
- SCAN_DIV, 24000: clock cycles each column is driven before advancing (1 ms at 24 MHz); must be ≥ 4.
- DEBOUNCE_CYCLES, 480000: consecutive stable cycles required to accept a press or a release (20 ms); must be ≥ 2.

Ports:
- clk, input, 1: single clock, 24 MHz.
- reset_n, input, 1: asynchronous, active-low reset.
- rows, input, 4: raw row lines, active-low (pulled up), asynchronous to clk.
- cols, output, 4: column drive, active-low, exactly one bit low at all times.
- key, output, 4: hex code of the last accepted key.
- key_valid, output, 1: one-cycle pulse when a new key is accepted.
- key_held, output, 1: high from acceptance until debounced release.

## Operation
- rows pass through a 2-flop synchronizer (reset value 4'b1111). All decisions use the synchronized value `rs`.
- Column index `ci` (0..3) drives cols = ~(1 << ci).
- Key map (row r top→bottom, col c left→right):
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D
- FSM states:
  - **SCAN**: a dwell counter counts 0..SCAN_DIV-1. On the final dwell cycle, sample `rs`.
    - Exactly one bit low: capture the row pattern, keep ci, clear the debounce counter, go to DEBOUNCE.
    - Otherwise (none low, or two or more low): ci advances mod 4, stay in SCAN.
  - **DEBOUNCE**: column held.
    - `rs` equals the captured pattern: increment the counter. On the cycle the counter reaches DEBOUNCE_CYCLES-1, go to HELD.
    - `rs` differs: go to SCAN with ci advanced, no output.
  - **HELD**: column held. When `rs` == 4'b1111, clear the counter and go to RELEASE. Any other pattern (including extra keys) is ignored; one-key lockout.
  - **RELEASE**: count consecutive cycles of `rs` == 4'b1111.
    - Any low row: return to HELD, no new pulse.
    - On reaching DEBOUNCE_CYCLES-1: key_held←0, ci advances, go to SCAN.
- Entering HELD from DEBOUNCE: key←map[row][ci], key_valid←1 for exactly that one cycle, key_held←1.
- key keeps its value until the next accepted press.
- Counters are sized with $clog2 of the larger parameter. The dwell counter resets to 0 on every state entry.

## Timing
- Reset values:
  - cols = 4'b1110 (ci=0)
  - key = 4'h0
  - key_valid = 0
  - key_held = 0
  - state SCAN
  - all counters 0
- Reset is asynchronous mid-operation from any state: outputs return to their reset values immediately, with no pulse emitted.
- Press latency: from the first cycle the raw row is stable low while its column is driven, 2 (sync) + up to SCAN_DIV (dwell) + DEBOUNCE_CYCLES cycles to key_valid.
- key, key_valid and key_held are registered, and change on the same edge on acceptance.
- Release latency: 2 + DEBOUNCE_CYCLES cycles from stable raw release to key_held falling.
- A bounce shorter than DEBOUNCE_CYCLES produces no key_valid.
- A continuous hold produces exactly one key_valid.
- Simultaneous events:
  - Reset wins over everything.
  - A sample on the final dwell cycle takes priority over column advance (the column does not advance when a press is captured).

## Structure
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}
  - 4x4 key-map constant array `logic [3:0] KEYMAP[4][4]`
  - a function returning the row index from a one-hot-low pattern
- Sub-module sync_2ff: a parameterized-width 2-flop synchronizer with reset value input. Instantiate it once for rows.
- Everything else lives in one always_ff FSM plus combinational next-state/decode logic.

## Test plan
Run with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- **Reset:** assert reset_n=0 mid-DEBOUNCE -> cols=4'b1110, key=0, key_valid=0, key_held=0 immediately. After release, scanning resumes 1110→1101→1011→0111 every 4 cycles.
- **Clean press "5":** rows=4'b1101 only while cols=4'b1101 (row1/col1), held 50 cycles -> exactly one key_valid pulse with key=4'h5, then key_held=1.
- **Bounce reject:** row0/col3 pulled low for 5 cycles then released, repeated 3 times -> no key_valid, key stays at its prior value.
- **Long hold:** press "0" (row3/col1) for 200 cycles -> a single key_valid with key=4'h0, key_held=1 throughout. Release with 3-cycle bounces -> no second pulse. key_held falls about 10 cycles after final release.
- **Multi-key:** rows=4'b1001 on col2 -> ignored, scan continues. Then press "A" during a hold of "1" -> no pulse; after release of both, key_held=0.
- **Wrap:** press "D" (row3/col3) -> key=4'hD. After release, scanning restarts at ci=0 (cols=1110).

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_e;

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] row_idx(
    input logic [3:0] pat
  );
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      !pat[0]: r = 2'd0;
      !pat[1]: r = 2'd1;
      !pat[2]: r = 2'd2;
      !pat[3]: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer with a
// reset value supplied as an input.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= rst_val;
      s2_q <= rst_val;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, debounce and
// one-key lockout for a 4x4 matrix keypad.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAXP =
    (SCAN_DIV > DEBOUNCE_CYCLES) ?
    SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(MAXP);
  localparam logic [CW-1:0] DWELL_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rs;
  kp_state_e     state_q, state_d;
  logic [1:0]    ci_q, ci_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  sync_2ff #(.W(4)) u_sync (
    .clk     (clk),
    .rst_n   (reset_n),
    .rst_val (4'b1111),
    .d       (rows),
    .q       (rs)
  );

  // state register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN;
      ci_q    <= 2'd0;
      dwell_q <= '0;
      cnt_q   <= '0;
      pat_q   <= 4'b1111;
      key_q   <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // next-state, counters and key decode
  always_comb begin
    state_d = state_q;
    ci_d    = ci_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if ($onehot(~rs)) begin
            pat_d   = rs;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            ci_d = ci_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs == pat_q) begin
          if (cnt_q == DEB_LAST) begin
            state_d = HELD;
            key_d   =
              KEYMAP[row_idx(pat_q)][ci_q];
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          ci_d    = ci_q + 2'd1;
          dwell_d = '0;
        end
      end
      HELD: begin
        if (rs == 4'b1111) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rs != 4'b1111) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          held_d  = 1'b0;
          ci_d    = ci_q + 2'd1;
          dwell_d = '0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign cols      = ~(4'b0001 << ci_q);
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: matrix-model stimulus with
// a queue scoreboard checked on key_valid.
module tb_keypad_scanner;

  logic        clk;
  logic        reset_n;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [3:0] exp_q[$];

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // physical switch matrix: a pressed key
  // shorts its row to its column when driven low
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c])
          rows[r] = 1'b0;
  end

  function automatic logic [15:0] k(
    input int r, input int c);
    logic [15:0] m;
    m = '0;
    m[r*4+c] = 1'b1;
    return m;
  endfunction

  // monitor: every pulse must match the queue
  always @(negedge clk) begin
    if (reset_n && key_valid) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: key=%h",
          key);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key !== e || key_held !== 1'b1) begin
          errors++;
          $display(
            "FAIL pulse_key: key=%h held=%b, required key=%h held=1",
            key, key_held, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk4(input string nm,
    input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h",
        nm, act, req);
    end
  endtask

  task automatic wait_held(input logic v,
    input int lim, input string nm);
    int n;
    n = 0;
    while (key_held !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_held !== v) begin
      errors++;
      $display("FAIL %s: key_held=%b required %b",
        nm, key_held, v);
    end
  endtask

  initial begin
    logic [3:0] c0;
    logic [3:0] e;
    pressed = '0;
    reset_n = 1'b0;
    tick(3);
    chk4("rst_cols", cols, 4'b1110);
    chk4("rst_key", key, 4'h0);
    chk4("rst_valid", {3'b0, key_valid}, 4'h0);
    chk4("rst_held", {3'b0, key_held}, 4'h0);
    reset_n = 1'b1;
    tick(2);

    // clean press of "5"
    exp_q.push_back(4'h5);
    pressed = k(1, 1);
    tick(45);
    chk4("press5_held", {3'b0, key_held}, 4'h1);
    tick(5);
    pressed = '0;
    wait_held(1'b0, 30, "press5_release");

    // bounce on "A"
    for (int i = 0; i < 3; i++) begin
      pressed = k(0, 3);
      tick(5);
      pressed = '0;
      tick(10);
    end
    chk4("bounce_key", key, 4'h5);
    chk4("bounce_held", {3'b0, key_held}, 4'h0);

    // long hold of "0" with bouncy release
    exp_q.push_back(4'h0);
    pressed = k(3, 1);
    tick(40);
    chk4("hold0_held_a", {3'b0, key_held}, 4'h1);
    tick(160);
    chk4("hold0_held_b", {3'b0, key_held}, 4'h1);
    chk4("hold0_key", key, 4'h0);
    for (int i = 0; i < 3; i++) begin
      pressed = '0;
      tick(4);
      pressed = k(3, 1);
      tick(3);
    end
    pressed = '0;
    tick(5);
    chk4("hold0_still", {3'b0, key_held}, 4'h1);
    wait_held(1'b0, 20, "hold0_release");

    // two keys in one column are ignored
    pressed = k(1, 2) | k(2, 2);
    tick(60);
    chk4("multi_held", {3'b0, key_held}, 4'h0);
    c0 = cols;
    tick(4);
    checks++;
    if (cols === c0) begin
      errors++;
      $display("FAIL multi_scan: cols stuck at %b",
        cols);
    end
    pressed = '0;
    tick(4);

    // "A" pressed during a hold of "1"
    exp_q.push_back(4'h1);
    pressed = k(0, 0);
    wait_held(1'b1, 40, "hold1_accept");
    tick(5);
    pressed = k(0, 0) | k(0, 3);
    tick(30);
    chk4("lockout_key", key, 4'h1);
    pressed = '0;
    wait_held(1'b0, 30, "lockout_release");

    // "D" then wrap to column 0
    exp_q.push_back(4'hD);
    pressed = k(3, 3);
    wait_held(1'b1, 40, "wrapD_accept");
    chk4("wrapD_key", key, 4'hD);
    tick(10);
    pressed = '0;
    wait_held(1'b0, 30, "wrapD_release");
    chk4("wrap_cols", cols, 4'b1110);

    // reset in the middle of debouncing "1"
    pressed = k(0, 0);
    tick(7);
    #2;
    reset_n = 1'b0;
    #1;
    chk4("mid_rst_cols", cols, 4'b1110);
    chk4("mid_rst_key", key, 4'h0);
    chk4("mid_rst_valid",
      {3'b0, key_valid}, 4'h0);
    chk4("mid_rst_held", {3'b0, key_held}, 4'h0);
    pressed = '0;
    tick(3);
    #2;
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      e = ~(4'b0001 << (i / 4));
      chk4("scan_seq", cols, e);
      @(negedge clk);
    end

    checks++;
    if (exp_q.size() != 0 || pulses != 4) begin
      errors++;
      $display(
        "FAIL pulse_total: pulses=%0d pending=%0d, required 4 and 0",
        pulses, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
